// File: rtl/seq1011_pkg.sv
// Shared definitions for the 1011-sync serial link (transmitter and detector).
package seq1011_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int unsigned SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq1011_frame_tx.sv
// Serial frame transmitter: sync preamble, then payload MSB first, then guard zeros.
// One word accepted per valid/ready handshake while idle.
module seq1011_frame_tx
    import seq1011_pkg::*;
#(
    parameter int unsigned        DATA_W   = 8,
    parameter int unsigned        PRE_W    = SYNC_W,
    parameter logic [PRE_W-1:0]   PREAMBLE = PRE_W'(SYNC_PATTERN),
    parameter int unsigned        GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              dout,
    output logic              dout_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned FRAME_W = PRE_W + DATA_W;
    localparam int unsigned MAX_LEN = max3(PRE_W, DATA_W, GAP_BITS);
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   sh_q, sh_d;
    logic                 dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 frame_done_q, frame_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Preamble and payload share one shift register; its MSB is the next serial bit.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = {PREAMBLE, in_data};
                    cnt_d   = '0;
                    state_d = PRE;
                end
            end
            PRE: begin
                sh_d = sh_q << 1;
                if (cnt_q == CNT_W'(PRE_W - 1)) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                sh_d = sh_q << 1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = (GAP_BITS == 0) ? IDLE : GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Registered outputs describe the cycle the next state covers.
        if ((state_d == PRE) || (state_d == DATA)) begin
            dout_d       = sh_d[FRAME_W-1];
            dout_valid_d = 1'b1;
        end
        frame_done_d = (state_d == DATA) && (cnt_d == CNT_W'(DATA_W - 1));
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seq1011_frame_tx.md
Name: seq1011_frame_tx

Overview:
Serial frame transmitter: the transmit end of the 1011-sync serial link.
- Accepts one parallel word per valid/ready handshake.
- Emits a fixed 4-bit "1011" sync preamble, then the word MSB first on a single-bit serial output.
- Follows each frame with a run of guard zeros.
- Drives the serial input of the existing 1011 Mealy detector on the receive side.

Parameters:
DATA_W, 8, payload width in bits (>=1)
PRE_W, 4, preamble length in bits (>=1)
PREAMBLE, 4'b1011, preamble pattern, sent MSB first, width PRE_W
GAP_BITS, 2, guard zero bits after each frame (>=0)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  payload word
dout  output  1  serial bit stream
dout_valid  output  1  dout carries a preamble or payload bit this cycle
frame_done  output  1  one-cycle pulse coincident with the last payload bit
busy  output  1  frame or guard in progress (state != IDLE)

Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset (async, immediate): state=IDLE; dout=0, dout_valid=0, frame_done=0; shift register and counter = 0.
- Reset combinational effect: in_ready=1 and busy=0 while rst is held.
- Outputs: dout, dout_valid and frame_done are flops. in_ready = (state==IDLE). busy = !in_ready.
- States: the state register describes the current cycle's dout.
  - IDLE: dout=0, dout_valid=0. Handshake (in_valid && in_ready) at edge: latch in_data, cnt=0, ->PRE.
  - PRE: dout=PREAMBLE[PRE_W-1-cnt], dout_valid=1. After PRE_W bits ->DATA, cnt=0.
  - DATA: dout=shreg MSB, shift left each cycle, dout_valid=1. After DATA_W bits ->GAP, or ->IDLE if GAP_BITS==0.
  - GAP: dout=0, dout_valid=0. After GAP_BITS cycles ->IDLE.
- Timing, handshake in cycle t:
  - Preamble occupies t+1..t+PRE_W.
  - Payload occupies t+PRE_W+1..t+PRE_W+DATA_W.
  - frame_done=1 in cycle t+PRE_W+DATA_W only.
  - in_ready returns at t+PRE_W+DATA_W+GAP_BITS+1.
- Throughput: minimum frame period is 1+PRE_W+DATA_W+GAP_BITS cycles; defaults give 15.
- Back-to-back: with in_valid held, the next word is accepted in the first IDLE cycle; no gap shortening.
- Input handling:
  - in_valid while busy is ignored; no latching, no error.
  - in_data is sampled only at the handshake edge; later changes have no effect.
- Counter: width $clog2(max(PRE_W,DATA_W,GAP_BITS)+1). It never wraps mid-phase; it reloads to 0 on each phase change.
- Reset mid-frame: frame is aborted, no frame_done, outputs drop immediately. After release, IDLE with in_ready=1. The partial frame is not resent.
- Payload content is unrestricted. Payloads containing 1011, or overlapping the preamble tail, are legal; the receiver's job to handle.

Decomposition:
- Package seq1011_pkg holds:
  - state typedef (IDLE, PRE, DATA, GAP; logic [1:0]);
  - constant SYNC_PATTERN=4'b1011;
  - constant SYNC_W=4.
- The detector shares this package and the PREAMBLE default references it.
- Single module; the PISO shift is a few lines, so no sub-module.

Test Plan:
- Reset, send 0xA5 (defaults):
  - dout over 12 valid cycles = 1,0,1,1,1,0,1,0,0,1,0,1;
  - frame_done only on the 12th;
  - then 2 cycles dout=0/dout_valid=0;
  - in_ready high exactly 15 cycles after the handshake.
- in_valid held with 0x3C then 0xFF:
  - second handshake exactly 15 cycles after the first;
  - streams 1011_00111100 then 1011_11111111;
  - in_ready low for the 14 intervening cycles.
- During frame of 0x81, pulse in_valid with in_data=0x00 and toggle in_data each cycle:
  - output still 1011_10000001;
  - exactly one frame_done.
- Assert rst asynchronously mid-payload (between edges, bit 3):
  - dout/dout_valid/frame_done go 0 without a clock edge;
  - no frame_done;
  - in_ready=1 after release;
  - next word 0x5A transmits cleanly.
- Loopback into the 1011 detector with 0x0B:
  - stream 1011_00001011 yields exactly 2 detector pulses, at payload bits 0 and 8 relative alignment (frame bits 4 and 12).
- GAP_BITS=0 build, back-to-back 0x01,0x02:
  - period 13 cycles;
  - in_ready high the cycle after the last payload bit;
  - dout_valid low only during that one IDLE cycle.
